// File: rtl/mul_fx_pipe_if.sv
// Bundle of the multiplier's flow-control and data signals.
// master = producer/consumer side driving operands and out_ready,
// slave  = the multiplier pipeline itself.
interface mul_fx_pipe_if #(
   parameter int N         = 16,
   parameter int R         = 8,
   parameter int PRECISION = 16,
   parameter int M         = 16
);
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [N-1:0]           a;
   logic [R+PRECISION-1:0] b;
   logic                   out_valid;
   logic                   out_ready;
   logic [M-1:0]           out;
   logic                   out_sat;

   modport master (
      output flush, in_valid, a, b, out_ready,
      input  in_ready, out_valid, out, out_sat
   );

   modport slave (
      input  flush, in_valid, a, b, out_ready,
      output in_ready, out_valid, out, out_sat
   );
endinterface

// File: rtl/mul_fx_pipe.sv
// mul_fx_pipe: pipelined unsigned fixed-point multiplier, out = sat_M((a*b) >> PRECISION).
// Optional build macro MUL_FX_PIPE_ROUND_EN selects round-half-up instead of truncation.
// Slot layout: slot 0 holds operands, middle slots hold the product,
// the last slot holds the shifted/saturated result (STAGES = 1 collapses all into one).
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// in_ready depends combinationally on out_ready through the slot chain; a producer
// must hold a/b/in_valid stable until accepted, and out/out_sat hold while
// out_valid & !out_ready. flush overrides every transfer and empties the pipe.
module mul_fx_pipe #(
   parameter int N         = 16,
   parameter int R         = 8,
   parameter int PRECISION = 16,
   parameter int M         = 16,
   parameter int STAGES    = 3
) (
   input logic           clk,
   input logic           rst_n,
   mul_fx_pipe_if.slave  bus
);
   localparam int BW = R + PRECISION;
   localparam int PW = N + BW;
   localparam int QW = N + R;
`ifdef MUL_FX_PIPE_ROUND_EN
   localparam int QX = QW + 1;
`else
   localparam int QX = QW;
`endif
   localparam logic [QX-1:0] MAXV = {{(QX-M){1'b0}}, {M{1'b1}}};

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] w_rdy;
   logic [STAGES-1:0] w_vup;
   logic [PW-1:0]     w_p0;
   logic [PW-1:0]     w_plast;
   logic [QX-1:0]     w_q;
   logic              w_sat;
   logic [M-1:0]      w_res;
   logic [M-1:0]      r_out;
   logic              r_sat;

   // Ready chain: a slot can load if it is empty or anything downstream can move.
   always_comb begin
      logic acc;
      acc   = bus.out_ready;
      w_rdy = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         acc      = acc | ~r_v[i];
         w_rdy[i] = acc;
      end
   end

   // Valid feeding each slot: the input for slot 0, the previous slot otherwise.
   always_comb begin
      w_vup    = '0;
      w_vup[0] = bus.in_valid;
      for (int i = 1; i < STAGES; i++) begin
         w_vup[i] = r_v[i-1];
      end
   end

   // Slot valid bits; flush empties the whole pipe ahead of any transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
      end else if (bus.flush) begin
         r_v <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (w_rdy[i]) r_v[i] <= w_vup[i];
         end
      end
   end

   generate
      if (STAGES >= 2) begin : g_opreg
         logic [N-1:0]  r_a;
         logic [BW-1:0] r_b;
         // Operand capture in slot 0 (data only, no reset needed).
         always_ff @(posedge clk) begin
            if (!bus.flush && w_rdy[0] && w_vup[0]) begin
               r_a <= bus.a;
               r_b <= bus.b;
            end
         end
         assign w_p0 = PW'(r_a) * PW'(r_b);
      end else begin : g_opcomb
         assign w_p0 = PW'(bus.a) * PW'(bus.b);
      end
   endgenerate

   generate
      if (STAGES >= 3) begin : g_mid
         localparam int NMID = STAGES - 2;
         logic [PW-1:0] r_mid [1:NMID];
         logic [PW-1:0] w_src [1:NMID];
         // Source of each product slot: fresh product for the first, previous slot after.
         always_comb begin
            w_src    = '{default: '0};
            w_src[1] = w_p0;
            for (int k = 2; k <= NMID; k++) begin
               w_src[k] = r_mid[k-1];
            end
         end
         // Product slots advance with the same rule as their valid bits.
         always_ff @(posedge clk) begin
            for (int k = 1; k <= NMID; k++) begin
               if (!bus.flush && w_rdy[k] && w_vup[k]) r_mid[k] <= w_src[k];
            end
         end
         assign w_plast = r_mid[NMID];
      end else begin : g_nomid
         assign w_plast = w_p0;
      end
   endgenerate

`ifdef MUL_FX_PIPE_ROUND_EN
   // One extra bit so adding the half-LSB can never wrap before saturation.
   logic [PW:0] w_pr;
   assign w_pr = {1'b0, w_plast} + ((PW+1)'(1) << (PRECISION - 1));
   assign w_q  = QX'(w_pr >> PRECISION);
`else
   assign w_q  = QX'(w_plast >> PRECISION);
`endif

   assign w_sat = (w_q > MAXV);
   assign w_res = w_sat ? {M{1'b1}} : w_q[M-1:0];

   // Result slot: reset to zero so out is defined right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
         r_sat <= 1'b0;
      end else if (!bus.flush && w_rdy[STAGES-1] && w_vup[STAGES-1]) begin
         r_out <= w_res;
         r_sat <= w_sat;
      end
   end

   assign bus.in_ready  = w_rdy[0];
   assign bus.out_valid = r_v[STAGES-1];
   assign bus.out       = r_out;
   assign bus.out_sat   = r_sat;
endmodule

// File: tb/tb_mul_fx_pipe.sv
// Directed bench for mul_fx_pipe (STAGES=3): latency, saturation, rounding,
// backpressure, flush, asynchronous reset, then a random stream against a model.
module tb_mul_fx_pipe;
   localparam int N         = 16;
   localparam int R         = 8;
   localparam int PRECISION = 16;
   localparam int M         = 16;
   localparam int STAGES    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [16:0] exp_q[$];
   logic [16:0] e_val;
   int accepted;
   int received;
   int n_stale;
   int sent;
   logic [15:0] exp_rnd;

   mul_fx_pipe_if #(.N(N), .R(R), .PRECISION(PRECISION), .M(M)) bus ();

   mul_fx_pipe #(.N(N), .R(R), .PRECISION(PRECISION), .M(M), .STAGES(STAGES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, required finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [16:0] model(input logic [15:0] a, input logic [23:0] b);
      logic [63:0] p;
      logic [63:0] q;
      p = 64'(a) * 64'(b);
`ifdef MUL_FX_PIPE_ROUND_EN
      q = (p + 64'h8000) >> 16;
`else
      q = p >> 16;
`endif
      if (q > 64'hFFFF) return {1'b1, 16'hFFFF};
      return {1'b0, q[15:0]};
   endfunction

   task automatic send_get(input string tag, input logic [15:0] a, input logic [23:0] b,
                           input logic [15:0] e_out, input logic e_sat);
      int waited;
      bus.out_ready = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.in_valid  = 1'b1;
      settle();
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      settle();
      waited = 0;
      while (bus.out_valid !== 1'b1 && waited < 20) begin
         step();
         settle();
         waited++;
      end
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_out"}, 32'(bus.out), 32'(e_out));
      check({tag, "_sat"}, 32'(bus.out_sat), 32'(e_sat));
      step();
   endtask

   task automatic count_stale(input int cycles);
      n_stale = 0;
      for (int i = 0; i < cycles; i++) begin
         settle();
         if (bus.out_valid !== 1'b0) n_stale++;
         step();
      end
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_out_sat", 32'(bus.out_sat), 32'd0);
      rst_n = 1'b1;
      settle();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      step();

      // Scale 1.5 with exact latency of 3
      bus.a        = 16'd100;
      bus.b        = 24'h018000;
      bus.in_valid = 1'b1;
      settle();
      check("lat_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      settle();
      check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
      step();
      settle();
      check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
      step();
      settle();
      check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
      check("lat_out", 32'(bus.out), 32'd150);
      check("lat_sat", 32'(bus.out_sat), 32'd0);
      step();

      // Saturation boundary and corners
      send_get("sat_hi", 16'hFFFF, 24'h020000, 16'hFFFF, 1'b1);
      send_get("sat_edge", 16'h7FFF, 24'h020000, 16'hFFFE, 1'b0);
      send_get("sat_max", 16'hFFFF, 24'hFFFFFF, 16'hFFFF, 1'b1);
      send_get("zero", 16'h0000, 24'hABCDEF, 16'h0000, 1'b0);

      // Rounding of an exact half
`ifdef MUL_FX_PIPE_ROUND_EN
      send_get("round_half", 16'd3, 24'h008000, 16'd2, 1'b0);
`else
      send_get("round_half", 16'd3, 24'h008000, 16'd1, 1'b0);
`endif

      // Backpressure: a=1..10, b=1.0, out_ready low for cycles 2..7
      accepted = 0;
      received = 0;
      exp_q.delete();
      for (int c = 0; c < 60; c++) begin
         bus.out_ready = !(c >= 2 && c <= 7);
         bus.in_valid  = (accepted < 10);
         bus.a         = 16'(accepted + 1);
         bus.b         = 24'h010000;
         settle();
         if (c == 5) begin
            check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
            check("bp_accepted", 32'(accepted), 32'd3);
         end
         if (c == 3 || c == 7) begin
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_out", 32'(bus.out), 32'd1);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("bp_unexpected", 32'(bus.out), 32'hFFFF_FFFF);
            end else begin
               e_val = exp_q.pop_front();
               check("bp_data", {15'b0, bus.out_sat, bus.out}, {15'b0, e_val});
            end
            received++;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back({1'b0, bus.a});
            accepted++;
         end
         step();
      end
      bus.in_valid = 1'b0;
      check("bp_received", 32'(received), 32'd10);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Flush a full pipe with an input offered in the same cycle
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'(5 + i);
         bus.b        = 24'h010000;
         step();
      end
      bus.a     = 16'd99;
      bus.flush = 1'b1;
      settle();
      check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
      check("flush_pre_out", 32'(bus.out), 32'd5);
      check("flush_in_ready_full", 32'(bus.in_ready), 32'd0);
      step();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      settle();
      check("flush_valid_next", 32'(bus.out_valid), 32'd0);
      count_stale(6);
      check("flush_no_stale", 32'(n_stale), 32'd0);

      // Flush on an empty pipe drops the offered input
      bus.a        = 16'd42;
      bus.b        = 24'h010000;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      settle();
      check("flush_in_ready_empty", 32'(bus.in_ready), 32'd1);
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      count_stale(6);
      check("flush_dropped", 32'(n_stale), 32'd0);

      // Asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'(8 + i);
         bus.b        = 24'h020000;
         step();
      end
      bus.in_valid = 1'b0;
      settle();
      check("arst_pre_valid", 32'(bus.out_valid), 32'd1);
      check("arst_pre_out", 32'(bus.out), 32'd16);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_out", 32'(bus.out), 32'd0);
      check("arst_sat", 32'(bus.out_sat), 32'd0);
      #1;
      rst_n = 1'b1;
      #1;
      check("arst_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.out_ready = 1'b1;
      count_stale(6);
      check("arst_no_stale", 32'(n_stale), 32'd0);

      // Random stream with random backpressure against the reference model
      sent = 0;
      exp_q.delete();
      for (int c = 0; c < 4000; c++) begin
         if (sent >= 300 && exp_q.size() == 0) break;
         bus.in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
         bus.a         = 16'($urandom_range(0, 16'hFFFF));
         if ($urandom_range(0, 7) == 0) bus.b = 24'($urandom_range(0, 24'hFFFFFF));
         else                           bus.b = 24'($urandom_range(0, 24'h03FFFF));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         settle();
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected", 32'(bus.out), 32'hFFFF_FFFF);
            end else begin
               e_val = exp_q.pop_front();
               check("rand_out", {15'b0, bus.out_sat, bus.out}, {15'b0, e_val});
            end
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back(model(bus.a, bus.b));
            sent++;
         end
         step();
      end
      bus.in_valid = 1'b0;
      check("rand_sent", 32'(sent), 32'd300);
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
